musa_pc_unit: RTL

//  Parametrised program-counter unit for the MUSA core: PC register, sequential

---
 rtl/musa_pc_unit.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/musa_pc_unit.sv
// Program-counter unit for the MUSA core: PC register, increment, jump/branch
// target selection and a hardware call/return stack with a RUN/FAULT FSM.
module musa_pc_unit #(
  parameter int                ADDR_W      = 18,
  parameter int                STACK_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   en,
  input  logic [2:0]                             op,
  input  logic                                   flag,
  input  logic [ADDR_W-1:0]                      reg_target,
  input  logic [ADDR_W-1:0]                      imm_target,
  input  logic [ADDR_W-1:0]                      brfl_target,
  input  logic                                   fault_clr,
  output logic [ADDR_W-1:0]                      pc,
  output logic [ADDR_W-1:0]                      stack_top,
  output logic [$clog2(STACK_DEPTH+1)-1:0]       stack_count,
  output logic                                   stack_full,
  output logic                                   stack_empty,
  output logic                                   fault,
  output logic [1:0]                             fault_code
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = $clog2(STACK_DEPTH);

  localparam logic [SP_W-1:0]   SP_ONE   = SP_W'(1);
  localparam logic [SP_W-1:0]   SP_ZERO  = SP_W'(0);
  localparam logic [SP_W-1:0]   SP_DEPTH = SP_W'(STACK_DEPTH);
  localparam logic [ADDR_W-1:0] PC_ONE   = ADDR_W'(1);

  localparam logic [2:0] OP_SEQ  = 3'd0;
  localparam logic [2:0] OP_JREG = 3'd1;
  localparam logic [2:0] OP_JIMM = 3'd2;
  localparam logic [2:0] OP_BRFL = 3'd3;
  localparam logic [2:0] OP_CALL = 3'd4;
  localparam logic [2:0] OP_RET  = 3'd5;

  localparam logic [1:0] CODE_NONE  = 2'b00;
  localparam logic [1:0] CODE_OVER  = 2'b01;
  localparam logic [1:0] CODE_UNDER = 2'b10;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [SP_W-1:0]     r_sp;
  logic [1:0]          r_fault_code;
  logic [ADDR_W-1:0]   r_stack [0:STACK_DEPTH-1];

  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   w_pc_nxt;
  logic [SP_W-1:0]     w_sp_nxt;
  logic [1:0]          w_code_nxt;
  logic                w_push;
  logic                w_full;
  logic                w_empty;
  logic [SP_W-1:0]     w_sp_m1;
  logic [IDX_W-1:0]    w_wr_idx;
  logic [IDX_W-1:0]    w_top_idx;
  logic [ADDR_W-1:0]   w_top;
  logic [ADDR_W-1:0]   w_pc_inc;

  assign w_full    = (r_sp == SP_DEPTH);
  assign w_empty   = (r_sp == SP_ZERO);
  assign w_sp_m1   = r_sp - SP_ONE;
  assign w_wr_idx  = r_sp[IDX_W-1:0];
  assign w_top_idx = w_sp_m1[IDX_W-1:0];
  // Empty stack must read as zero even though popped entries keep old data.
  assign w_top     = w_empty ? '0 : r_stack[w_top_idx];
  assign w_pc_inc  = r_pc + PC_ONE;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_sp_nxt    = r_sp;
    w_code_nxt  = r_fault_code;
    w_push      = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (en) begin
          case (op)
            OP_SEQ:  w_pc_nxt = w_pc_inc;
            OP_JREG: w_pc_nxt = reg_target;
            OP_JIMM: w_pc_nxt = imm_target;
            OP_BRFL: w_pc_nxt = flag ? brfl_target : w_pc_inc;
            OP_CALL: begin
              if (!w_full) begin
                w_push   = 1'b1;
                w_pc_nxt = imm_target;
                w_sp_nxt = r_sp + SP_ONE;
              end else begin
                w_state_nxt = ST_FAULT;
                w_code_nxt  = CODE_OVER;
              end
            end
            OP_RET: begin
              if (!w_empty) begin
                w_pc_nxt = w_top + PC_ONE;
                w_sp_nxt = w_sp_m1;
              end else begin
                w_state_nxt = ST_FAULT;
                w_code_nxt  = CODE_UNDER;
              end
            end
            default: w_pc_nxt = r_pc;
          endcase
        end else begin
          w_pc_nxt = r_pc;
        end
      end
      ST_FAULT: begin
        if (fault_clr) begin
          w_state_nxt = ST_RUN;
          w_pc_nxt    = RESET_PC;
          w_sp_nxt    = SP_ZERO;
          w_code_nxt  = CODE_NONE;
        end else begin
          w_state_nxt = ST_FAULT;
        end
      end
      default: begin
        w_state_nxt = ST_FAULT;
        w_code_nxt  = CODE_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_RUN;
      r_pc         <= RESET_PC;
      r_sp         <= SP_ZERO;
      r_fault_code <= CODE_NONE;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_sp         <= w_sp_nxt;
      r_fault_code <= w_code_nxt;
    end
  end

  // The call address pushed is the PC of the CALL itself; RET resumes at top+1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        r_stack[i] <= '0;
      end
    end else if (w_push) begin
      r_stack[w_wr_idx] <= r_pc;
    end
  end

  assign pc          = r_pc;
  assign stack_top   = w_top;
  assign stack_count = r_sp;
  assign stack_full  = w_full;
  assign stack_empty = w_empty;
  assign fault       = (r_state == ST_FAULT);
  assign fault_code  = r_fault_code;

endmodule
